// File: rtl/goldschmidt_pkg.sv
// Shared types and Q2.(WIDTH-2) fixed-point constants for the Goldschmidt divider datapath.
package goldschmidt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } prenorm_state_t;

  localparam int unsigned GS_DATA_W = 24;
  localparam int unsigned GS_WIDTH  = 30;
  localparam int unsigned ONE_BIT   = GS_WIDTH - 2;
  localparam int unsigned HALF_BIT  = GS_WIDTH - 3;

  // 0.75 initial reciprocal seed for the divider iterations
  localparam logic [GS_WIDTH-1:0] K0 = GS_WIDTH'(3) << (GS_WIDTH - 4);

endpackage

// File: rtl/goldschmidt_prenorm_lane.sv
// One operand lane: shift register with leading-zero counter, normalizing toward bit WIDTH-3.
// GS_PRENORM_FAST_EN enables 4-bit skips when the top four fraction bits are clear.
module prenorm_lane
  import goldschmidt_pkg::*;
#(
  parameter int unsigned WIDTH = GS_WIDTH,
  parameter int unsigned CNT_W = $clog2(GS_DATA_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] val_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_c,
  output logic             zero_c
);

  localparam int unsigned HB = WIDTH - 3;

  logic [WIDTH-1:0] val_q, val_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done_c = val_q[HB];
  assign zero_c = (val_q == '0);
  assign val_o  = val_q;
  assign cnt_o  = cnt_q;

  // Normalized or zero lanes hold; others shift toward the half bit
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (load_i) begin
      val_d = load_val_i;
      cnt_d = '0;
    end else if (step_i && !done_c && !zero_c) begin
`ifdef GS_PRENORM_FAST_EN
      if (val_q[HB -: 4] == 4'd0) begin
        val_d = val_q << 4;
        cnt_d = cnt_q + CNT_W'(4);
      end else begin
        val_d = val_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
`else
      val_d = val_q << 1;
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      val_q <= '0;
      cnt_q <= '0;
    end else begin
      val_q <= val_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/goldschmidt_prenorm.sv
// Operand pre-normalizer for the Goldschmidt divider: scales both operands into [0.5,1.0).
// Optional GS_PRENORM_FAST_EN shortens latency via 4-bit lane skips; results are unchanged.
module goldschmidt_prenorm
  import goldschmidt_pkg::*;
#(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned WIDTH  = 30,
  parameter int unsigned CNT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  numerator,
  output logic [WIDTH-1:0]  denominator,
  output logic [CNT_W:0]    exp,
  output logic              div_zero
);

  localparam int unsigned LOAD_SH = WIDTH - 2 - DATA_W;

  prenorm_state_t state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [CNT_W:0] exp_q, exp_d;
  logic           div_zero_q, div_zero_d;

  logic             load_c, step_c, lanes_done_c;
  logic [WIDTH-1:0] num_load_c, den_load_c;
  logic [CNT_W-1:0] num_cnt, den_cnt;
  logic             num_done, num_zero, den_done, den_zero;

  assign num_load_c   = WIDTH'(dividend) << LOAD_SH;
  assign den_load_c   = WIDTH'(divisor) << LOAD_SH;
  assign lanes_done_c = (num_done || num_zero) && (den_done || den_zero);

  prenorm_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_num (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_c),
    .load_val_i (num_load_c),
    .step_i     (step_c),
    .val_o      (numerator),
    .cnt_o      (num_cnt),
    .done_c     (num_done),
    .zero_c     (num_zero)
  );

  prenorm_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_den (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_c),
    .load_val_i (den_load_c),
    .step_i     (step_c),
    .val_o      (denominator),
    .cnt_o      (den_cnt),
    .done_c     (den_done),
    .zero_c     (den_zero)
  );

  assign in_ready  = (state_q == IDLE) && reset;
  assign out_valid = out_valid_q;
  assign exp       = exp_q;
  assign div_zero  = div_zero_q;

  // Next-state and control decode
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    exp_d       = exp_q;
    div_zero_d  = div_zero_q;
    load_c      = 1'b0;
    step_c      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          load_c  = 1'b1;
          state_d = NORM;
        end
      end
      NORM: begin
        if (lanes_done_c) begin
          exp_d       = (CNT_W+1)'(den_cnt) - (CNT_W+1)'(num_cnt);
          div_zero_d  = den_zero;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          step_c = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      exp_q       <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      exp_q       <= exp_d;
      div_zero_q  <= div_zero_d;
    end
  end

endmodule
